// File: rtl/band_pkg.sv
// band_pkg: shared sample types, capture states and magnitude helper for the band path.
package band_pkg;
  typedef logic signed [15:0] sample_t;
  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} capture_state_t;
  // |x| in 17 bits so -32768 is representable before saturating to SAMPLE_MAX
  function automatic logic [15:0] sat_abs(input sample_t x);
    logic [16:0] m;
    m = x[15] ? 17'(-{x[15], x}) : {x[15], x};
    return (m > 17'h07FFF) ? SAMPLE_MAX : m[15:0];
  endfunction
endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample buffer, one write port, read-first synchronous read.
module capture_ram import band_pkg::*; #(
  parameter int DEPTH = 4036,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  sample_t       wd,
  input  logic [AW-1:0] ra,
  output sample_t       q
);
  sample_t mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    q <= mem[ra];
  end
endmodule

// File: rtl/band_capture.sv
// band_capture: records one buffer of 44 kHz samples with count and peak tracking, plus read-back.
module band_capture import band_pkg::*; #(
  parameter int MEM_DEPTH = 4036,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  sample_t               data_in,
  input  logic                  valid_in,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output sample_t               rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   sample_count,
  output logic [15:0]           peak_abs
);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);
  capture_state_t state;
  logic [15:0] mag;
  logic we, rd_ok;
  sample_t q;
  assign we = state == CAPTURE && valid_in && !abort;
  assign mag = sat_abs(data_in);
  capture_ram #(.DEPTH(MEM_DEPTH), .AW(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .we(we),
    .wa(sample_count[ADDR_WIDTH-1:0]),
    .wd(data_in),
    .ra(rd_addr),
    .q(q)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sample_count <= '0;
      peak_abs <= '0;
      rd_ok <= 1'b0;
    end else begin
      rd_ok <= {1'b0, rd_addr} < DEPTH;
      case (state)
        IDLE, DONE: if (start) begin
          state <= CAPTURE;
          sample_count <= '0;
          peak_abs <= '0;
        end
        CAPTURE: if (abort) state <= IDLE;
        else if (valid_in) begin
          sample_count <= sample_count + 1'b1;
          if (mag > peak_abs) peak_abs <= mag;
          if (sample_count == LAST) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // out-of-range reads return zero, qualified one cycle later to match RAM latency
  assign rd_data = rd_ok ? q : '0;
  assign busy = state == CAPTURE;
  assign done = state == DONE;
endmodule

// File: tb/tb_band_capture.sv
// tb_band_capture: directed self-checking bench for band_capture.
module tb_band_capture;
  localparam int MEM_DEPTH = 4036;
  localparam int AW = 12;
  logic clk = 0, rst = 1, valid_in = 0, start = 0, abort = 0;
  logic signed [15:0] data_in = 0, rd_data;
  logic [AW-1:0] rd_addr = 0;
  logic busy, done;
  logic [AW:0] sample_count;
  logic [15:0] peak_abs;
  int total = 0, bad = 0;

  band_capture #(.MEM_DEPTH(MEM_DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .start(start),
    .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .sample_count(sample_count), .peak_abs(peak_abs)
  );

  always #5 clk = ~clk;

  task automatic strobe(input logic [15:0] d);
    data_in = d; valid_in = 1;
    @(negedge clk);
    valid_in = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_addr = a;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 0 || done !== 0) begin bad++; $display("FAIL reset_flags busy=%b done=%b want 0 0", busy, done); end
    total++; if (sample_count !== 0) begin bad++; $display("FAIL reset_count got %0d want 0", sample_count); end
    total++; if (peak_abs !== 0 || rd_data !== 0) begin bad++; $display("FAIL reset_peak_rd peak=%h rd=%h want 0 0", peak_abs, rd_data); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_idle_discard();
    rd_addr = 0;
    strobe(16'h1234);
    strobe(16'h1234);
    total++; if (sample_count !== 0 || busy !== 0 || done !== 0) begin bad++; $display("FAIL idle_discard count=%0d busy=%b done=%b want 0 0 0", sample_count, busy, done); end
    rd(0);
    total++; if (rd_data === 16'h1234) begin bad++; $display("FAIL idle_rd0 got %h want not 1234", rd_data); end
  endtask

  task automatic test_full();
    pulse_start();
    total++; if (busy !== 1 || sample_count !== 0) begin bad++; $display("FAIL full_start busy=%b count=%0d want 1 0", busy, sample_count); end
    for (int i = 0; i < MEM_DEPTH; i++) begin
      strobe(16'(i));
      if (i == MEM_DEPTH - 2) begin
        total++; if (busy !== 1 || done !== 0) begin bad++; $display("FAIL full_penult busy=%b done=%b want 1 0", busy, done); end
      end
    end
    total++; if (busy !== 0 || done !== 1) begin bad++; $display("FAIL full_done busy=%b done=%b want 0 1", busy, done); end
    total++; if (sample_count !== 13'(MEM_DEPTH)) begin bad++; $display("FAIL full_count got %0d want %0d", sample_count, MEM_DEPTH); end
    total++; if (peak_abs !== 16'd4035) begin bad++; $display("FAIL full_peak got %h want 0fc3", peak_abs); end
    rd(0);    total++; if (rd_data !== 16'd0)    begin bad++; $display("FAIL rd_0 got %h want 0000", rd_data); end
    rd(1);    total++; if (rd_data !== 16'd1)    begin bad++; $display("FAIL rd_1 got %h want 0001", rd_data); end
    rd(2000); total++; if (rd_data !== 16'd2000) begin bad++; $display("FAIL rd_2000 got %h want 07d0", rd_data); end
    rd(4035); total++; if (rd_data !== 16'd4035) begin bad++; $display("FAIL rd_4035 got %h want 0fc3", rd_data); end
    rd(4036); total++; if (rd_data !== 16'd0)    begin bad++; $display("FAIL rd_oor4036 got %h want 0000", rd_data); end
    rd(4095); total++; if (rd_data !== 16'd0)    begin bad++; $display("FAIL rd_oor4095 got %h want 0000", rd_data); end
    rd_addr = 0;
    strobe(16'h1234);
    abort = 1; @(negedge clk); abort = 0;
    total++; if (done !== 1 || sample_count !== 13'(MEM_DEPTH)) begin bad++; $display("FAIL done_hold done=%b count=%0d want 1 %0d", done, sample_count, MEM_DEPTH); end
    rd(0);    total++; if (rd_data !== 16'd0)    begin bad++; $display("FAIL done_discard got %h want 0000", rd_data); end
  endtask

  task automatic test_peak();
    pulse_start();
    strobe(16'sd100);
    strobe(-16'sd200);
    total++; if (peak_abs !== 16'd200) begin bad++; $display("FAIL peak_200 got %h want 00c8", peak_abs); end
    strobe(-16'sd32768);
    strobe(16'sd50);
    total++; if (peak_abs !== 16'h7FFF || sample_count !== 4) begin bad++; $display("FAIL peak_sat peak=%h count=%0d want 7fff 4", peak_abs, sample_count); end
    abort = 1; @(negedge clk); abort = 0;
    pulse_start();
    total++; if (peak_abs !== 0) begin bad++; $display("FAIL peak_clear got %h want 0000", peak_abs); end
    strobe(16'sd5);
    strobe(-16'sd7);
    strobe(16'sd3);
    total++; if (peak_abs !== 16'd7) begin bad++; $display("FAIL peak_7 got %h want 0007", peak_abs); end
    abort = 1; @(negedge clk); abort = 0;
    total++; if (busy !== 0 || peak_abs !== 16'd7 || sample_count !== 3) begin bad++; $display("FAIL peak_abort busy=%b peak=%h count=%0d want 0 0007 3", busy, peak_abs, sample_count); end
  endtask

  task automatic test_abort();
    pulse_start();
    for (int i = 0; i < 10; i++) strobe(16'h1000 + 16'(i));
    data_in = 16'hBEEF; valid_in = 1; abort = 1;
    @(negedge clk);
    valid_in = 0; abort = 0;
    total++; if (busy !== 0 || done !== 0 || sample_count !== 10) begin bad++; $display("FAIL abort_state busy=%b done=%b count=%0d want 0 0 10", busy, done, sample_count); end
    total++; if (peak_abs !== 16'h1009) begin bad++; $display("FAIL abort_peak got %h want 1009", peak_abs); end
    rd(9);  total++; if (rd_data !== 16'h1009) begin bad++; $display("FAIL abort_rd9 got %h want 1009", rd_data); end
    rd(10); total++; if (rd_data !== 16'd10)   begin bad++; $display("FAIL abort_rd10 got %h want 000a", rd_data); end
  endtask

  task automatic test_collisions();
    data_in = 16'h5555; valid_in = 1; start = 1;
    @(negedge clk);
    valid_in = 0; start = 0;
    total++; if (busy !== 1 || sample_count !== 0) begin bad++; $display("FAIL start_valid busy=%b count=%0d want 1 0", busy, sample_count); end
    strobe(16'h0001);
    pulse_start();
    total++; if (busy !== 1 || sample_count !== 1) begin bad++; $display("FAIL start_in_capture busy=%b count=%0d want 1 1", busy, sample_count); end
    strobe(16'h0002);
    total++; if (sample_count !== 2) begin bad++; $display("FAIL count_continue got %0d want 2", sample_count); end
    rd(0); total++; if (rd_data !== 16'h0001) begin bad++; $display("FAIL start_valid_rd0 got %h want 0001", rd_data); end
    for (int i = 2; i < MEM_DEPTH; i++) strobe(16'(i));
    total++; if (done !== 1 || sample_count !== 13'(MEM_DEPTH)) begin bad++; $display("FAIL b2b_done done=%b count=%0d want 1 %0d", done, sample_count, MEM_DEPTH); end
    pulse_start();
    total++; if (busy !== 1 || done !== 0 || sample_count !== 0) begin bad++; $display("FAIL restart busy=%b done=%b count=%0d want 1 0 0", busy, done, sample_count); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 500; i++) strobe(16'h2000 + 16'(i));
    total++; if (sample_count !== 500) begin bad++; $display("FAIL pre_reset_count got %0d want 500", sample_count); end
    rd_addr = 5;
    @(posedge clk);
    #2 rst = 1;
    #1;
    total++; if (busy !== 0 || done !== 0 || sample_count !== 0 || peak_abs !== 0 || rd_data !== 0) begin bad++; $display("FAIL async_reset busy=%b done=%b count=%0d peak=%h rd=%h want all 0", busy, done, sample_count, peak_abs, rd_data); end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    pulse_start();
    rd_addr = 0; data_in = 16'h7777; valid_in = 1;
    @(negedge clk);
    valid_in = 0;
    total++; if (rd_data !== 16'h2000) begin bad++; $display("FAIL read_first got %h want 2000", rd_data); end
    total++; if (sample_count !== 1) begin bad++; $display("FAIL resume_count got %0d want 1", sample_count); end
    rd(0); total++; if (rd_data !== 16'h7777) begin bad++; $display("FAIL resume_rd0 got %h want 7777", rd_data); end
  endtask

  initial begin
    test_reset();
    test_idle_discard();
    test_full();
    test_peak();
    test_abort();
    test_collisions();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/band_capture.md
# band_capture

Sample recorder for the band path: writes a 44 kHz stream of signed 16-bit samples into an on-chip buffer, up to MEM_DEPTH samples per capture, for later read-back. It is the writing counterpart of the band playback modules, which read a sample memory at the 44 kHz strobe. It sits after the sample source (ADC/filter output) in the 4.4 MHz domain. Captures can be read out by the playback/analysis logic through a synchronous read port.

## Interface
Parameters:
- MEM_DEPTH, 4036, number of samples per capture (buffer size)
- ADDR_WIDTH, $clog2(MEM_DEPTH), buffer address width

Ports:
- clk  in  1  system clock, 4.4 MHz
- rst  in  1  reset, asynchronous, active-high
- data_in  in  16  signed sample
- valid_in  in  1  sample strobe, one-cycle pulse at ≤44 kHz
- start  in  1  one-cycle pulse, begin a new capture
- abort  in  1  one-cycle pulse, stop the current capture
- rd_addr  in  ADDR_WIDTH  read-back address
- rd_data  out  16  signed read-back sample
- busy  out  1  high while capturing
- done  out  1  high once a full buffer has been captured
- sample_count  out  ADDR_WIDTH+1  samples written in the current/last capture
- peak_abs  out  16  largest |sample| in the current/last capture

## Operation
- FSM states: IDLE, CAPTURE, DONE. Reset → IDLE.
- IDLE: start → CAPTURE. Entering CAPTURE clears the write address, sample_count and peak_abs to 0.
- CAPTURE: each valid_in writes data_in to address sample_count, increments sample_count and updates peak_abs.
- The write at address MEM_DEPTH-1 → DONE. sample_count = MEM_DEPTH.
- CAPTURE: abort → IDLE. sample_count and peak_abs keep their values. Abort wins over a simultaneous valid_in, so that sample is not written.
- DONE: start → CAPTURE (fresh capture). abort has no effect.
- start in CAPTURE is ignored.
- start cycle: any valid_in in the same cycle is not captured. The first captured sample is the next valid_in.
- Magnitude: |x| is computed in 17 bits. -32768 saturates to 32767, so peak_abs ≤ 16'h7FFF. peak_abs updates when |x| > peak_abs.
- No wrap-around: the buffer is never overwritten within one capture. valid_in in IDLE or DONE is discarded.
- busy = (state == CAPTURE). done = (state == DONE).
- Read port:
  - rd_addr < MEM_DEPTH → registered memory data.
  - rd_addr ≥ MEM_DEPTH → rd_data = 0.
  - Read and write to the same address in the same cycle → old data.
- Buffer contents are not reset. Only control state is reset.

## Timing
- Reset values: busy 0, done 0, sample_count 0, peak_abs 0, rd_data 0. State IDLE.
- start at cycle N → busy = 1 at N+1.
- valid_in at cycle N → memory written at the N clock edge. sample_count and peak_abs updated at N+1.
- Final write at cycle N → busy 0, done 1 at N+1.
- abort at cycle N → busy 0 at N+1.
- rd_data latency: 1 cycle from rd_addr.
- rst asserted mid-capture → immediate IDLE. Outputs go to their reset values asynchronously, and the partial buffer is left undefined for the consumer.

## Structure
- Shared package band_pkg holds:
  - sample_t: logic signed [15:0]
  - SAMPLE_MAX: 16'sh7FFF
  - capture_state_t enum: IDLE/CAPTURE/DONE
- Sub-module capture_ram: simple dual-port RAM, one write port and one synchronous read port, MEM_DEPTH × 16. Inferred as BRAM with read-first behaviour. The top level handles the out-of-range read zeroing.

## Test plan
- Reset then idle: no start, drive valid_in with 0x1234 → sample_count 0, done 0, busy 0, and rd_data at address 0 is not affected by the discarded sample.
- Full capture: start, then MEM_DEPTH strobes with data = index → done at the cycle after the last write, sample_count = MEM_DEPTH, and read-back of addr k returns k one cycle later.
- Peak/saturation: capture containing 100, -200, -32768, 50 → peak_abs = 0x7FFF. Capture containing 5, -7, 3 → peak_abs = 7.
- Abort: start, 10 strobes, then abort coinciding with an 11th strobe → IDLE, sample_count = 10, and address 10 is not written.
- Edge collisions:
  - start with simultaneous valid_in → sample not captured.
  - start during CAPTURE → ignored, count continues.
  - start in DONE → count back to 0.
- Reset mid-capture after 500 samples → outputs at reset values immediately. A fresh start resumes at address 0.
